// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

    localparam int unsigned HZ_MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - operand forwarding select for one Execute ALU input
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output fwd_sel_t   sel_o
);

    // Memory result is younger than Writeback, so it wins; x0 never forwards.
    always_comb begin
        sel_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
            sel_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control, memory-wait FSM, watchdog and counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int unsigned MEM_TIMEOUT = HZ_MEM_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            Rs1D,
    input  logic [4:0]            Rs2D,
    input  logic [4:0]            Rs1E,
    input  logic [4:0]            Rs2E,
    input  logic [4:0]            RdE,
    input  logic [4:0]            RdM,
    input  logic [4:0]            RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  LoadE,
    input  logic                  PCSrcE,
    input  logic                  MemAccessM,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  mem_timeout,
    output logic [DATA_WIDTH-1:0] stall_cycles,
    output logic [DATA_WIDTH-1:0] flush_count
);

    localparam int             CW     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LIM = CW'(MEM_TIMEOUT);

    hz_state_t             state_q, state_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                  timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [DATA_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    fwd_sel_t              fwd_a, fwd_b;
    logic                  lw_stall;
    logic                  freeze;

    fwd_sel u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_b)
    );

    assign lw_stall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_req   = MemAccessM & ~rst;
    assign freeze    = mem_req & ~mem_ready;
    assign ForwardAE = rst ? FWD_RF : fwd_a;
    assign ForwardBE = rst ? FWD_RF : fwd_b;

    // State register for the memory-wait FSM, watchdog and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next state: enter WAIT on a freeze; leave on completion or a dropped access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (freeze) state_d = WAIT;
            WAIT:    if (mem_ready || !MemAccessM) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Watchdog counts WAIT cycles and latches the flag on the cycle the count reaches the limit.
    always_comb begin
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        if (state_q == WAIT) begin
            wait_cnt_d = (wait_cnt_q == TO_LIM) ? wait_cnt_q : wait_cnt_q + CW'(1);
            if (wait_cnt_q >= TO_LIM - CW'(1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((freeze || (lw_stall && !PCSrcE)) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + DATA_WIDTH'(1);
        end
        if (PCSrcE && !freeze && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + DATA_WIDTH'(1);
        end
    end

    // Stall/flush outputs in priority order: reset, memory freeze, branch, load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule
